// File: rtl/tlda_line_drawer_pkg.sv
// Shared types and constants for the TLDA line-drawing engine.
// Coordinates are carried internally as signed 11-bit values.
package tlda_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 11;
    localparam int TW = 9;

    typedef logic signed [CW-1:0] coord_t;
    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLOT,
        STEP,
        FINISH
    } state_t;

    function automatic coord_t iabs(input coord_t v);
        return v[CW-1] ? -v : v;
    endfunction

endpackage

// File: rtl/tlda_line_drawer_if.sv
// Pixel write port from the line drawer toward the pixel buffer.
// The sink stalls a request by holding pixel_waitrequest high.
interface tlda_line_drawer_if;
    import tlda_pkg::*;

    logic            pixel_write;
    logic [XW-1:0]   pixel_x;
    logic [YW-1:0]   pixel_y;
    rgb565_t         pixel_color;
    logic            pixel_waitrequest;

    modport master (
        output pixel_write,
        output pixel_x,
        output pixel_y,
        output pixel_color,
        input  pixel_waitrequest
    );

    modport slave (
        input  pixel_write,
        input  pixel_x,
        input  pixel_y,
        input  pixel_color,
        output pixel_waitrequest
    );

endinterface

// File: rtl/tlda_line_drawer_span_gen.sv
// Perpendicular span walker: steps the minor offset on each accepted slot,
// flags the last slot of a span and pixels lying outside the screen.
module tlda_span_gen
    import tlda_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          adv,
    input  coord_t        start,
    input  logic [TW-1:0] count,
    input  coord_t        major,
    input  logic          steep,
    output coord_t        px,
    output coord_t        py,
    output logic          last,
    output logic          off
);

    coord_t        cur;
    logic [TW-1:0] rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
            rem <= '0;
        end else if (load) begin
            cur <= start;
            rem <= count;
        end else if (adv) begin
            cur <= cur + coord_t'(1);
            rem <= rem - 1'b1;
        end
    end

    // Minor axis is x on steep lines, y otherwise.
    assign px   = steep ? cur : major;
    assign py   = steep ? major : cur;
    assign last = (rem == TW'(1));

    assign off = px[CW-1] || (px >= coord_t'(H_RES))
              || py[CW-1] || (py >= coord_t'(V_RES));

endmodule

// File: rtl/tlda_line_drawer.sv
// Bresenham line engine emitting thick spans as single-pixel writes.
// Define TLDA_CLIP_EN to suppress writes of off-screen pixels.
module tlda_line_drawer
    import tlda_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [XW-1:0]      x0,
    input  logic [XW-1:0]      x1,
    input  logic [YW-1:0]      y0,
    input  logic [YW-1:0]      y1,
    input  logic [TW-1:0]      thickness,
    input  rgb565_t            color,
    output logic               done,
    tlda_line_drawer_if.master pix
);

`ifdef TLDA_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    state_t        state;
    state_t        nxt;

    coord_t        cx0;
    coord_t        cx1;
    coord_t        cy0;
    coord_t        cy1;
    logic [TW-1:0] t_eff;
    rgb565_t       col;

    coord_t        major;
    coord_t        minor;
    coord_t        major_end;
    coord_t        dx;
    coord_t        dy;
    coord_t        err;
    logic          ystep_neg;
    logic          steep;

    coord_t        adx;
    coord_t        ady;
    logic          st;
    coord_t        sx0;
    coord_t        sy0;
    coord_t        sx1;
    coord_t        sy1;
    logic          sw;
    coord_t        ax;
    coord_t        ay;
    coord_t        bx;
    coord_t        by;

    coord_t        err_dec;
    coord_t        step_err;
    coord_t        step_minor;
    coord_t        span_minor;
    logic [TW-1:0] tm1;
    coord_t        half;
    coord_t        span_start;

    logic          load;
    logic          adv;
    logic          last;
    logic          off;
    logic          skip;
    coord_t        px;
    coord_t        py;

    // Octant folding from the captured endpoints.
    assign adx = iabs(cx1 - cx0);
    assign ady = iabs(cy1 - cy0);
    assign st  = ady > adx;
    assign sx0 = st ? cy0 : cx0;
    assign sy0 = st ? cx0 : cy0;
    assign sx1 = st ? cy1 : cx1;
    assign sy1 = st ? cx1 : cy1;
    assign sw  = sx0 > sx1;
    assign ax  = sw ? sx1 : sx0;
    assign ay  = sw ? sy1 : sy0;
    assign bx  = sw ? sx0 : sx1;
    assign by  = sw ? sy0 : sy1;

    assign err_dec  = err - dy;
    assign step_err = err_dec[CW-1] ? err_dec + dx : err_dec;
    assign step_minor = !err_dec[CW-1] ? minor
                      : ystep_neg ? minor - coord_t'(1)
                      : minor + coord_t'(1);

    // Span is centred on the line, extra pixel of even spans goes high.
    assign span_minor = (state == INIT) ? ay : step_minor;
    assign tm1        = t_eff - 1'b1;
    assign half       = coord_t'({2'b00, tm1 >> 1});
    assign span_start = span_minor - half;

    assign skip = CLIP && off;
    assign load = (state == INIT) || (state == STEP);
    assign adv  = (state == PLOT) && (skip || !pix.pixel_waitrequest);

    tlda_span_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_span (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .adv   (adv),
        .start (span_start),
        .count (t_eff),
        .major (major),
        .steep (steep),
        .px    (px),
        .py    (py),
        .last  (last),
        .off   (off)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (go) nxt = INIT;
            INIT:    nxt = PLOT;
            PLOT: begin
                if (adv && last) begin
                    nxt = (major == major_end) ? FINISH : STEP;
                end
            end
            STEP:    nxt = PLOT;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx0       <= '0;
            cx1       <= '0;
            cy0       <= '0;
            cy1       <= '0;
            t_eff     <= '0;
            col       <= '0;
            major     <= '0;
            minor     <= '0;
            major_end <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            ystep_neg <= 1'b0;
            steep     <= 1'b0;
        end else begin
            if (state == IDLE && go) begin
                cx0   <= coord_t'({2'b00, x0});
                cx1   <= coord_t'({2'b00, x1});
                cy0   <= coord_t'({3'b000, y0});
                cy1   <= coord_t'({3'b000, y1});
                t_eff <= (thickness == '0) ? TW'(1) : thickness;
                col   <= color;
            end
            if (state == INIT) begin
                major     <= ax;
                minor     <= ay;
                major_end <= bx;
                dx        <= bx - ax;
                dy        <= iabs(by - ay);
                err       <= (bx - ax) >>> 1;
                ystep_neg <= by < ay;
                steep     <= st;
            end
            if (state == STEP) begin
                major <= major + coord_t'(1);
                minor <= step_minor;
                err   <= step_err;
            end
        end
    end

    assign done            = (state == IDLE);
    assign pix.pixel_write = (state == PLOT) && !skip;
    assign pix.pixel_x     = px[XW-1:0];
    assign pix.pixel_y     = py[YW-1:0];
    assign pix.pixel_color = col;

endmodule

// File: tb/tb_tlda_line_drawer.sv
// Directed bench for tlda_line_drawer with a queue-based pixel model.
// Build with or without TLDA_CLIP_EN; the model follows the same macro.
module tb_tlda_line_drawer;

    logic        clk;
    logic        reset;
    logic        go;
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  y1;
    logic [8:0]  thickness;
    logic [15:0] color;
    logic        done;

    tlda_line_drawer_if pix();

    tlda_line_drawer dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .thickness (thickness),
        .color     (color),
        .done      (done),
        .pix       (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    int          accepted;
    logic [32:0] exp_q[$];

    function automatic int iab(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected write sequence from the plain Bresenham description.
    task automatic model_line(input int ax0, input int ay0, input int ax1,
                              input int ay1, input int t,
                              input logic [15:0] c, output int npts);
        int tt, st, a0, b0, a1, b1, tmp, dmaj, dmin, e, m, stp, px, py;
        tt = (t == 0) ? 1 : t;
        st = (iab(ay1 - ay0) > iab(ax1 - ax0)) ? 1 : 0;
        if (st != 0) begin
            a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1;
        end else begin
            a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1;
        end
        if (a0 > a1) begin
            tmp = a0; a0 = a1; a1 = tmp;
            tmp = b0; b0 = b1; b1 = tmp;
        end
        dmaj = a1 - a0;
        dmin = iab(b1 - b0);
        stp  = (b1 >= b0) ? 1 : -1;
        e    = dmaj / 2;
        m    = b0;
        npts = dmaj + 1;
        for (int a = a0; a <= a1; a++) begin
            for (int k = 0; k < tt; k++) begin
                int s;
                s  = m - (tt - 1) / 2 + k;
                px = (st != 0) ? s : a;
                py = (st != 0) ? a : s;
`ifdef TLDA_CLIP_EN
                if (px >= 0 && px < 320 && py >= 0 && py < 240)
                    exp_q.push_back({px[8:0], py[7:0], c});
`else
                exp_q.push_back({px[8:0], py[7:0], c});
`endif
            end
            e = e - dmin;
            if (e < 0) begin
                m = m + stp;
                e = e + dmaj;
            end
        end
    endtask

    task automatic pin_pt(input string name, input int idx, input int x,
                          input int y);
        logic [32:0] e;
        e = (idx < exp_q.size()) ? exp_q[idx] : '1;
        chk(name, 64'(e[32:16]), 64'({x[8:0], y[7:0]}));
    endtask

    task automatic run_line(input int ax0, input int ay0, input int ax1,
                            input int ay1, input int t,
                            input logic [15:0] c, input int extra,
                            input bit lat, input string name);
        int npts, tt, cyc, first_wr;
        model_line(ax0, ay0, ax1, ay1, t, c, npts);
        tt = (t == 0) ? 1 : t;
        @(posedge clk); #1;
        x0 = 9'(ax0); y0 = 8'(ay0);
        x1 = 9'(ax1); y1 = 8'(ay1);
        thickness = 9'(t); color = c;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk({name, "_done_fall"}, 64'(done), 64'(0));
        cyc = 0;
        first_wr = -1;
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (pix.pixel_write && first_wr < 0) first_wr = cyc;
        end
        chk({name, "_cycles"}, 64'(cyc), 64'(npts * (tt + 1) + 1 + extra));
        if (lat) chk({name, "_latency"}, 64'(first_wr), 64'(1));
        chk({name, "_left"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        int n, k, base;
        logic [32:0] cur, held, e;
        bit prev_stall;

        vectors     = 0;
        miscompares = 0;
        accepted    = 0;
        reset = 1'b1;
        go = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        thickness = '0; color = '0;
        pix.pixel_waitrequest = 1'b0;
        prev_stall = 1'b0;
        held = '0;

        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    prev_stall = 1'b0;
                end else begin
                    cur = {pix.pixel_x, pix.pixel_y, pix.pixel_color};
                    if (prev_stall) begin
                        chk("stall_write", 64'(pix.pixel_write), 64'(1));
                        chk("stall_hold", 64'(cur), 64'(held));
                    end
                    if (pix.pixel_write && !pix.pixel_waitrequest) begin
                        accepted++;
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL extra_pixel: actual x=%0d y=%0d required none",
                                     pix.pixel_x, pix.pixel_y);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pixel", 64'(cur), 64'(e));
                        end
                    end
                    prev_stall = pix.pixel_write && pix.pixel_waitrequest;
                    held = cur;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(done), 64'(1));
        chk("rst_write", 64'(pix.pixel_write), 64'(0));
        chk("rst_x", 64'(pix.pixel_x), 64'(0));
        chk("rst_y", 64'(pix.pixel_y), 64'(0));
        chk("rst_color", 64'(pix.pixel_color), 64'(0));
        reset = 1'b0;

        model_line(0, 0, 3, 0, 1, 16'hF800, n);
        chk("pin_h_n", 64'(exp_q.size()), 64'(4));
        pin_pt("pin_h0", 0, 0, 0);
        pin_pt("pin_h3", 3, 3, 0);
        chk("pin_h_col", 64'(exp_q[0][15:0]), 64'(16'hF800));
        exp_q.delete();
        run_line(0, 0, 3, 0, 1, 16'hF800, 0, 1, "horiz");

        model_line(6, 3, 5, 0, 1, 16'h1234, n);
        pin_pt("pin_s0", 0, 5, 0);
        pin_pt("pin_s1", 1, 5, 1);
        pin_pt("pin_s2", 2, 6, 2);
        pin_pt("pin_s3", 3, 6, 3);
        exp_q.delete();
        run_line(5, 0, 6, 3, 1, 16'h1234, 0, 1, "steep");
        run_line(6, 3, 5, 0, 1, 16'h4321, 0, 1, "steep_rev");

        model_line(10, 10, 10, 10, 3, 16'h07E0, n);
        chk("pin_t3_n", 64'(exp_q.size()), 64'(3));
        pin_pt("pin_t3a", 0, 10, 9);
        pin_pt("pin_t3c", 2, 10, 11);
        exp_q.delete();
        run_line(10, 10, 10, 10, 3, 16'h07E0, 0, 1, "thick3");
        run_line(10, 10, 10, 10, 0, 16'h001F, 0, 1, "thick0");

        model_line(0, 0, 1, 0, 3, 16'hFFFF, n);
`ifdef TLDA_CLIP_EN
        chk("pin_clip_n", 64'(exp_q.size()), 64'(4));
        pin_pt("pin_clip0", 0, 0, 0);
        pin_pt("pin_clip3", 3, 1, 1);
`else
        chk("pin_wrap_n", 64'(exp_q.size()), 64'(6));
        pin_pt("pin_wrap0", 0, 0, 255);
        pin_pt("pin_wrap5", 5, 1, 1);
`endif
        exp_q.delete();
        run_line(0, 0, 1, 0, 3, 16'hFFFF, 0, 0, "clip");

        base = accepted;
        fork
            run_line(0, 0, 3, 0, 1, 16'hABCD, 5, 1, "stall");
            begin
                k = 0;
                while (!(pix.pixel_write && accepted == base + 1) && k < 60) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk("stall_reach", 64'(k < 60), 64'(1));
                pix.pixel_waitrequest = 1'b1;
                x0 = 9'd100;
                go = 1'b1;
                @(posedge clk); #1;
                go = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                pix.pixel_waitrequest = 1'b0;
            end
        join

        model_line(0, 0, 3, 0, 1, 16'h5555, n);
        base = accepted;
        @(posedge clk); #1;
        x0 = 9'd0; y0 = 8'd0; x1 = 9'd3; y1 = 8'd0;
        thickness = 9'd1; color = 16'h5555;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        k = 0;
        while (accepted < base + 2 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midrst_reach", 64'(k < 60), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_done", 64'(done), 64'(1));
        chk("midrst_write", 64'(pix.pixel_write), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        run_line(0, 0, 3, 0, 1, 16'h5555, 0, 1, "after_rst");

        run_line(20, 30, 5, 25, 2, 16'h0F0F, 0, 1, "back_shallow");
        run_line(310, 200, 319, 239, 4, 16'hC0DE, 0, 0, "edge_steep");
        run_line(0, 239, 319, 0, 1, 16'h8001, 0, 1, "diag_full");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
